// File: rtl/instr_dispatch_queue.sv
// In-order instruction queue feeding the reservation station; one dispatch per cycle, NOP when idle.
// Optional DISPATCH_STATS_EN adds saturating stallCycles/dispatchCount outputs.
module instr_dispatch_queue #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3,
    parameter logic [2:0]  NOP_OP = 3'b111
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic [8:0]        loadInstr,
    input  logic              loadValid,
    output logic              loadReady,
    input  logic              RS_addSubFull,
    input  logic              RS_mulDivFull,
    output logic [8:0]        instrOut,
    output logic              dispatched,
    output logic              illegalOp,
    output logic [ADDR_W:0]   queueCount,
    output logic              queueEmpty,
    output logic              queueFull
`ifdef DISPATCH_STATS_EN
    ,
    output logic [15:0]       stallCycles,
    output logic [15:0]       dispatchCount
`endif
);

    logic [8:0]        mem [DEPTH];
    logic [ADDR_W-1:0] headPtr;
    logic [ADDR_W-1:0] tailPtr;
    logic [ADDR_W:0]   count;
    logic              illegalQ;

    logic [8:0] headInstr;
    logic [2:0] headOp;
    logic       nonEmpty;
    logic       isAS, isMD, isIllegal, isNop;
    logic       asFree, mdFree;
    logic       doDispatch, doPop, doPush;

    assign headInstr = mem[headPtr];
    assign headOp    = headInstr[8:6];
    assign nonEmpty  = (count != '0);

    always_comb begin
        isAS      = 1'b0;
        isMD      = 1'b0;
        isIllegal = 1'b0;
        isNop     = 1'b0;
        if (nonEmpty) begin
            case (headOp)
                3'b000, 3'b001: isAS  = 1'b1;
                3'b010, 3'b011: isMD  = 1'b1;
                3'b111:         isNop = 1'b1;
                default:        isIllegal = 1'b1;
            endcase
        end
    end

    // A full flag that is not a clean 0 (including X) fails the test and blocks.
    always_comb begin
        asFree = 1'b0;
        mdFree = 1'b0;
        if (RS_addSubFull == 1'b0) asFree = 1'b1;
        if (RS_mulDivFull == 1'b0) mdFree = 1'b1;
    end

    assign doDispatch = (isAS && asFree) || (isMD && mdFree);
    assign doPop      = doDispatch || isIllegal || isNop;
    assign queueFull  = (count == (ADDR_W+1)'(DEPTH));
    assign loadReady  = Resetn && !queueFull;
    assign doPush     = loadValid && loadReady;

    assign instrOut   = doDispatch ? headInstr : {NOP_OP, 6'b0};
    assign dispatched = doDispatch;
    assign illegalOp  = illegalQ;
    assign queueCount = count;
    assign queueEmpty = !nonEmpty;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            headPtr  <= '0;
            tailPtr  <= '0;
            count    <= '0;
            illegalQ <= 1'b0;
        end else begin
            if (doPush) tailPtr <= tailPtr + ADDR_W'(1);
            if (doPop)  headPtr <= headPtr + ADDR_W'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
            illegalQ <= isIllegal;
        end
    end

    always_ff @(posedge Clock) begin
        if (doPush) mem[tailPtr] <= loadInstr;
    end

`ifdef DISPATCH_STATS_EN
    logic headStalled;
    assign headStalled = (isAS && !asFree) || (isMD && !mdFree);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            stallCycles   <= '0;
            dispatchCount <= '0;
        end else begin
            if (headStalled && stallCycles != 16'hFFFF)
                stallCycles <= stallCycles + 16'd1;
            if (doDispatch && dispatchCount != 16'hFFFF)
                dispatchCount <= dispatchCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_dispatch_queue.sv
// Directed, table-driven bench for instr_dispatch_queue plus hand-written full/reset/stats sequences.
module tb_instr_dispatch_queue;

    localparam logic [8:0] NOPW = 9'h1C0;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic [8:0] loadInstr;
    logic       loadValid;
    logic       loadReady;
    logic       RS_addSubFull;
    logic       RS_mulDivFull;
    logic [8:0] instrOut;
    logic       dispatched;
    logic       illegalOp;
    logic [3:0] queueCount;
    logic       queueEmpty;
    logic       queueFull;
`ifdef DISPATCH_STATS_EN
    logic [15:0] stallCycles;
    logic [15:0] dispatchCount;
`endif

    int tests = 0;
    int fails = 0;

    always #5 Clock = ~Clock;

    instr_dispatch_queue #(.DEPTH(8), .ADDR_W(3), .NOP_OP(3'b111)) dut (
        .Clock         (Clock),
        .Resetn        (Resetn),
        .loadInstr     (loadInstr),
        .loadValid     (loadValid),
        .loadReady     (loadReady),
        .RS_addSubFull (RS_addSubFull),
        .RS_mulDivFull (RS_mulDivFull),
        .instrOut      (instrOut),
        .dispatched    (dispatched),
        .illegalOp     (illegalOp),
        .queueCount    (queueCount),
        .queueEmpty    (queueEmpty),
        .queueFull     (queueFull)
`ifdef DISPATCH_STATS_EN
        ,
        .stallCycles   (stallCycles),
        .dispatchCount (dispatchCount)
`endif
    );

    typedef struct {
        logic       lv;
        logic [8:0] li;
        logic       asF;
        logic       mdF;
        logic [8:0] eOut;
        logic       eDisp;
        logic       eIll;
        logic [3:0] eCnt;
        logic       eRdy;
    } vec_t;

    vec_t vecs[22];
    logic [8:0] exp8[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic lv, input logic [8:0] li, input logic asF, input logic mdF);
        loadValid     = lv;
        loadInstr     = li;
        RS_addSubFull = asF;
        RS_mulDivFull = mdF;
    endtask

    task automatic nextCycle();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    initial begin
        // rows: lv, li, asF, mdF | instrOut, dispatched, illegalOp, queueCount, loadReady (before the edge)
        vecs[0]  = '{1'b1, 9'h00A, 1'b0, 1'b0, NOPW,   1'b0, 1'b0, 4'd0, 1'b1};
        vecs[1]  = '{1'b0, 9'h000, 1'b0, 1'b0, 9'h00A, 1'b1, 1'b0, 4'd1, 1'b1};
        vecs[2]  = '{1'b0, 9'h000, 1'b0, 1'b0, NOPW,   1'b0, 1'b0, 4'd0, 1'b1};
        vecs[3]  = '{1'b1, 9'h09C, 1'b0, 1'b1, NOPW,   1'b0, 1'b0, 4'd0, 1'b1};
        vecs[4]  = '{1'b1, 9'h02E, 1'b0, 1'b1, NOPW,   1'b0, 1'b0, 4'd1, 1'b1};
        vecs[5]  = '{1'b0, 9'h000, 1'b0, 1'b1, NOPW,   1'b0, 1'b0, 4'd2, 1'b1};
        vecs[6]  = '{1'b0, 9'h000, 1'b0, 1'b1, NOPW,   1'b0, 1'b0, 4'd2, 1'b1};
        vecs[7]  = '{1'b0, 9'h000, 1'b0, 1'b1, NOPW,   1'b0, 1'b0, 4'd2, 1'b1};
        vecs[8]  = '{1'b0, 9'h000, 1'b0, 1'b0, 9'h09C, 1'b1, 1'b0, 4'd2, 1'b1};
        vecs[9]  = '{1'b0, 9'h000, 1'b0, 1'b0, 9'h02E, 1'b1, 1'b0, 4'd1, 1'b1};
        vecs[10] = '{1'b0, 9'h000, 1'b0, 1'b0, NOPW,   1'b0, 1'b0, 4'd0, 1'b1};
        vecs[11] = '{1'b1, 9'h140, 1'b0, 1'b0, NOPW,   1'b0, 1'b0, 4'd0, 1'b1};
        vecs[12] = '{1'b1, 9'h013, 1'b0, 1'b0, NOPW,   1'b0, 1'b0, 4'd1, 1'b1};
        vecs[13] = '{1'b0, 9'h000, 1'b0, 1'b0, 9'h013, 1'b1, 1'b1, 4'd1, 1'b1};
        vecs[14] = '{1'b0, 9'h000, 1'b0, 1'b0, NOPW,   1'b0, 1'b0, 4'd0, 1'b1};
        vecs[15] = '{1'b1, 9'h1D1, 1'b0, 1'b0, NOPW,   1'b0, 1'b0, 4'd0, 1'b1};
        vecs[16] = '{1'b0, 9'h000, 1'b0, 1'b0, NOPW,   1'b0, 1'b0, 4'd1, 1'b1};
        vecs[17] = '{1'b0, 9'h000, 1'b0, 1'b0, NOPW,   1'b0, 1'b0, 4'd0, 1'b1};
        vecs[18] = '{1'b1, 9'h00A, 1'b1, 1'b0, NOPW,   1'b0, 1'b0, 4'd0, 1'b1};
        vecs[19] = '{1'b0, 9'h000, 1'b1, 1'b0, NOPW,   1'b0, 1'b0, 4'd1, 1'b1};
        vecs[20] = '{1'b0, 9'h000, 1'b0, 1'b0, 9'h00A, 1'b1, 1'b0, 4'd1, 1'b1};
        vecs[21] = '{1'b0, 9'h000, 1'b0, 1'b0, NOPW,   1'b0, 1'b0, 4'd0, 1'b1};

        Resetn = 1'b0;
        drive(1'b1, 9'h00A, 1'b0, 1'b0);
        #2;
        chk("rst.instrOut",   32'(instrOut),   32'(NOPW));
        chk("rst.dispatched", 32'(dispatched), 0);
        chk("rst.illegalOp",  32'(illegalOp),  0);
        chk("rst.queueCount", 32'(queueCount), 0);
        chk("rst.queueEmpty", 32'(queueEmpty), 1);
        chk("rst.queueFull",  32'(queueFull),  0);
        chk("rst.loadReady",  32'(loadReady),  0);
        @(negedge Clock);
        Resetn = 1'b1;

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].lv, vecs[i].li, vecs[i].asF, vecs[i].mdF);
            #1;
            chk($sformatf("v%0d.instrOut", i),   32'(instrOut),   32'(vecs[i].eOut));
            chk($sformatf("v%0d.dispatched", i), 32'(dispatched), 32'(vecs[i].eDisp));
            chk($sformatf("v%0d.illegalOp", i),  32'(illegalOp),  32'(vecs[i].eIll));
            chk($sformatf("v%0d.queueCount", i), 32'(queueCount), 32'(vecs[i].eCnt));
            chk($sformatf("v%0d.queueEmpty", i), 32'(queueEmpty), 32'(vecs[i].eCnt == 4'd0));
            chk($sformatf("v%0d.loadReady", i),  32'(loadReady),  32'(vecs[i].eRdy));
            nextCycle();
        end

        // Fill to capacity with both classes blocked, then drain in order.
        for (int i = 0; i < 8; i++) begin
            exp8[i] = {1'b0, 2'(i), 3'(i), 3'(7 - i)};
            drive(1'b1, exp8[i], 1'b1, 1'b1);
            #1;
            chk($sformatf("fill%0d.queueCount", i), 32'(queueCount), 32'(i));
            chk($sformatf("fill%0d.dispatched", i), 32'(dispatched), 0);
            nextCycle();
        end
        drive(1'b1, 9'h00F, 1'b1, 1'b1);
        #1;
        chk("full.queueFull",  32'(queueFull),  1);
        chk("full.loadReady",  32'(loadReady),  0);
        chk("full.queueCount", 32'(queueCount), 8);
        nextCycle();
        #1;
        chk("push9.queueCount", 32'(queueCount), 8);
        drive(1'b1, 9'h00F, 1'b0, 1'b0);
        #1;
        chk("drain0.instrOut",  32'(instrOut),  32'(exp8[0]));
        chk("drain0.loadReady", 32'(loadReady), 0);
        nextCycle();
        drive(1'b0, 9'h000, 1'b0, 1'b0);
        #1;
        chk("drain0.noPush", 32'(queueCount), 7);
        for (int i = 1; i < 8; i++) begin
            #1;
            chk($sformatf("drain%0d.instrOut", i),   32'(instrOut),   32'(exp8[i]));
            chk($sformatf("drain%0d.dispatched", i), 32'(dispatched), 1);
            nextCycle();
        end
        #1;
        chk("drained.queueEmpty", 32'(queueEmpty), 1);
        chk("drained.instrOut",   32'(instrOut),   32'(NOPW));

        // Asynchronous reset between edges with five entries queued.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 9'h00A, 1'b1, 1'b1);
            nextCycle();
        end
        drive(1'b0, 9'h000, 1'b0, 1'b0);
        #1;
        chk("preRst.instrOut", 32'(instrOut), 32'(9'h00A));
        #1;
        Resetn = 1'b0;
        #1;
        chk("midRst.queueCount", 32'(queueCount), 0);
        chk("midRst.instrOut",   32'(instrOut),   32'(NOPW));
        chk("midRst.dispatched", 32'(dispatched), 0);
        chk("midRst.loadReady",  32'(loadReady),  0);
        @(negedge Clock);
        Resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("postRst%0d.dispatched", i), 32'(dispatched), 0);
            chk($sformatf("postRst%0d.queueCount", i), 32'(queueCount), 0);
            nextCycle();
        end

`ifdef DISPATCH_STATS_EN
        #1;
        chk("stats.rstStall", 32'(stallCycles),   0);
        chk("stats.rstDisp",  32'(dispatchCount), 0);
        drive(1'b1, 9'h00A, 1'b1, 1'b0);
        nextCycle();
        drive(1'b1, 9'h04B, 1'b1, 1'b0);
        nextCycle();
        drive(1'b0, 9'h000, 1'b1, 1'b0);
        nextCycle();
        nextCycle();
        drive(1'b0, 9'h000, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        #1;
        chk("stats.stallCycles",   32'(stallCycles),   3);
        chk("stats.dispatchCount", 32'(dispatchCount), 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
